dpr16_fifo_ctl: RTL and testbench



---
 rtl/dpr16_fifo_pkg.sv | 15 +
 rtl/dpr16_fifo_flags.sv | 45 ++++
 rtl/dpr16_fifo_ctl.sv | 121 ++++++++++++
 tb/tb_dpr16_fifo_ctl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpr16_fifo_pkg.sv
// Shared sizing and state type for the dpr16 FIFO controller.
// Imported by the controller top and its flag sub-module.
package dpr16_fifo_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 2;
  localparam int CNT_W  = 5;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/dpr16_fifo_flags.sv
// Occupancy counter plus registered almost-full/almost-empty flags.
// Ports: CK, RST, push, pop, flush in; count, afull, aempty out.
module dpr16_fifo_flags
  import dpr16_fifo_pkg::*;
#(
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             afull,
  output logic             aempty
);

  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Flags come from the next count so they line up with count.
  always_ff @(posedge CK) begin
    if (RST) begin
      count  <= '0;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      count  <= count_nxt;
      afull  <= count_nxt >= CNT_W'(AFULL_LEVEL);
      aempty <= count_nxt <= CNT_W'(AEMPTY_LEVEL);
    end
  end

endmodule

// File: rtl/dpr16_fifo_ctl.sv
// FWFT FIFO controller around a 16x2 dual-port distributed RAM.
// Ports: producer/consumer valid-ready, FLUSH, COUNT/flags, RAM pins.
module dpr16_fifo_ctl
  import dpr16_fifo_pkg::*;
#(
  parameter bit SCRUB        = 1'b1,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              PUSH_VALID,
  output logic              PUSH_READY,
  input  logic [DATA_W-1:0] PUSH_DATA,
  output logic              POP_VALID,
  input  logic              POP_READY,
  output logic [DATA_W-1:0] POP_DATA,
  input  logic              FLUSH,
  output logic [CNT_W-1:0]  COUNT,
  output logic              AFULL,
  output logic              AEMPTY,
  output logic              INIT_DONE,
  output logic [ADDR_W-1:0] RAM_WAD,
  output logic [DATA_W-1:0] RAM_DI,
  output logic              RAM_WRE,
  output logic              RAM_WPE,
  output logic [ADDR_W-1:0] RAM_RAD,
  input  logic [DATA_W-1:0] RAM_RDO
);

  localparam state_t RST_STATE = SCRUB ? ST_INIT : ST_RUN;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] scrub_cnt;
  logic [ADDR_W-1:0] scrub_nxt;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  count;
  logic              run;
  logic              full;
  logic              empty;
  logic              flush_run;
  logic              push_fire;
  logic              pop_fire;

  // Handshakes are held off while RST is asserted.
  assign run       = (state == ST_RUN) & ~RST;
  assign full      = count == CNT_W'(DEPTH);
  assign empty     = count == '0;
  assign flush_run = run & FLUSH;

  assign PUSH_READY = run & ~full & ~FLUSH;
  assign POP_VALID  = run & ~empty & ~FLUSH;
  assign push_fire  = PUSH_VALID & PUSH_READY;
  assign pop_fire   = POP_VALID & POP_READY;

  assign POP_DATA  = RAM_RDO;
  assign RAM_RAD   = rptr;
  assign RAM_WPE   = 1'b1;
  assign INIT_DONE = state == ST_RUN;
  assign COUNT     = count;

  always_ff @(posedge CK) begin
    if (RST) begin
      state     <= RST_STATE;
      scrub_cnt <= '0;
    end else begin
      state     <= state_nxt;
      scrub_cnt <= scrub_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    scrub_nxt = scrub_cnt;
    RAM_WAD   = wptr;
    RAM_DI    = '0;
    RAM_WRE   = 1'b0;
    unique case (state)
      ST_INIT: begin
        RAM_WAD   = scrub_cnt;
        RAM_WRE   = ~RST;
        scrub_nxt = scrub_cnt + 1'b1;
        if (scrub_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        RAM_DI  = run ? PUSH_DATA : '0;
        RAM_WRE = push_fire;
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST || flush_run) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_fire) wptr <= wptr + 1'b1;
      if (pop_fire) rptr <= rptr + 1'b1;
    end
  end

  dpr16_fifo_flags #(
    .AFULL_LEVEL (AFULL_LEVEL),
    .AEMPTY_LEVEL(AEMPTY_LEVEL)
  ) u_flags (
    .CK    (CK),
    .RST   (RST),
    .push  (push_fire),
    .pop   (pop_fire),
    .flush (flush_run),
    .count (count),
    .afull (AFULL),
    .aempty(AEMPTY)
  );

endmodule

// File: tb/tb_dpr16_fifo_ctl.sv
// Scoreboard bench for dpr16_fifo_ctl with a behavioural 16x2 RAM.
// Random and directed traffic; monitor checks every RUN cycle.
module tb_dpr16_fifo_ctl;

  logic       CK = 1'b0;
  logic       RST;
  logic       PUSH_VALID;
  logic       PUSH_READY;
  logic [1:0] PUSH_DATA;
  logic       POP_VALID;
  logic       POP_READY;
  logic [1:0] POP_DATA;
  logic       FLUSH;
  logic [4:0] COUNT;
  logic       AFULL;
  logic       AEMPTY;
  logic       INIT_DONE;
  logic [3:0] RAM_WAD;
  logic [1:0] RAM_DI;
  logic       RAM_WRE;
  logic       RAM_WPE;
  logic [3:0] RAM_RAD;
  logic [1:0] RAM_RDO;

  always #5 CK = ~CK;

  dpr16_fifo_ctl #(
    .SCRUB       (1'b1),
    .AFULL_LEVEL (14),
    .AEMPTY_LEVEL(2)
  ) dut (
    .CK        (CK),
    .RST       (RST),
    .PUSH_VALID(PUSH_VALID),
    .PUSH_READY(PUSH_READY),
    .PUSH_DATA (PUSH_DATA),
    .POP_VALID (POP_VALID),
    .POP_READY (POP_READY),
    .POP_DATA  (POP_DATA),
    .FLUSH     (FLUSH),
    .COUNT     (COUNT),
    .AFULL     (AFULL),
    .AEMPTY    (AEMPTY),
    .INIT_DONE (INIT_DONE),
    .RAM_WAD   (RAM_WAD),
    .RAM_DI    (RAM_DI),
    .RAM_WRE   (RAM_WRE),
    .RAM_WPE   (RAM_WPE),
    .RAM_RAD   (RAM_RAD),
    .RAM_RDO   (RAM_RDO)
  );

  // RAM: pins captured on rising edge, array written on falling edge.
  logic [1:0] mem [16];
  logic [3:0] wad_q;
  logic [1:0] di_q;
  logic       wre_q = 1'b0;
  logic       seeded = 1'b0;

  always @(posedge CK) begin
    wad_q <= RAM_WAD;
    di_q  <= RAM_DI;
    wre_q <= RAM_WRE & RAM_WPE;
  end

  always @(negedge CK) begin
    if (!seeded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 2'b01 | 2'($urandom);
      seeded <= 1'b1;
    end else if (wre_q) begin
      mem[wad_q] <= di_q;
    end
  end

  assign RAM_RDO = mem[RAM_RAD];

  int         ncmp = 0;
  int         nfail = 0;
  logic [1:0] q[$];
  int         wr_idx = 0;
  int         rd_idx = 0;
  bit         mon_en = 1'b0;

  task automatic chk(string n, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // Monitor: sample late in the cycle, compare, then advance the model.
  always begin
    @(negedge CK);
    #2;
    if (mon_en) begin
      int  n;
      bit  epr;
      bit  epv;
      bit  pf;
      bit  pp;
      n   = q.size();
      epr = (n != 16) && !FLUSH;
      epv = (n != 0) && !FLUSH;
      pf  = PUSH_VALID && epr;
      pp  = POP_READY && epv;
      chk("count", int'(COUNT), n);
      chk("push_ready", int'(PUSH_READY), int'(epr));
      chk("pop_valid", int'(POP_VALID), int'(epv));
      chk("afull", int'(AFULL), int'(n >= 14));
      chk("aempty", int'(AEMPTY), int'(n <= 2));
      chk("init_done", int'(INIT_DONE), 1);
      chk("ram_wpe", int'(RAM_WPE), 1);
      chk("ram_rad", int'(RAM_RAD), rd_idx % 16);
      chk("ram_wad", int'(RAM_WAD), wr_idx % 16);
      chk("ram_wre", int'(RAM_WRE), int'(pf));
      if (pf) chk("ram_di", int'(RAM_DI), int'(PUSH_DATA));
      if (pp) begin
        chk("pop_data", int'(POP_DATA), int'(q[0]));
        void'(q.pop_front());
        rd_idx++;
      end
      if (pf) begin
        q.push_back(PUSH_DATA);
        wr_idx++;
      end
      if (FLUSH) begin
        q.delete();
        wr_idx = 0;
        rd_idx = 0;
      end
    end
  end

  task automatic cyc(bit pv, logic [1:0] pd, bit pr, bit fl);
    PUSH_VALID = pv;
    PUSH_DATA  = pd;
    POP_READY  = pr;
    FLUSH      = fl;
    @(posedge CK);
    #1;
  endtask

  task automatic goto_count(int n);
    int g = 0;
    while (q.size() != n && g < 60) begin
      cyc(q.size() < n, 2'($urandom), q.size() > n, 1'b0);
      g++;
    end
    chk("goto_count", int'(COUNT), n);
  endtask

  // Reset for two cycles, then watch the scrub; abort_at >= 0 stops early.
  task automatic reset_seq(int abort_at);
    RST = 1'b1;
    PUSH_VALID = 1'b0;
    POP_READY = 1'b0;
    FLUSH = 1'b0;
    q.delete();
    wr_idx = 0;
    rd_idx = 0;
    @(posedge CK);
    #1;
    @(negedge CK);
    #2;
    chk("rst_wre", int'(RAM_WRE), 0);
    chk("rst_wad", int'(RAM_WAD), 0);
    chk("rst_di", int'(RAM_DI), 0);
    chk("rst_rad", int'(RAM_RAD), 0);
    chk("rst_wpe", int'(RAM_WPE), 1);
    chk("rst_push_ready", int'(PUSH_READY), 0);
    chk("rst_pop_valid", int'(POP_VALID), 0);
    chk("rst_count", int'(COUNT), 0);
    chk("rst_afull", int'(AFULL), 0);
    chk("rst_aempty", int'(AEMPTY), 1);
    chk("rst_init_done", int'(INIT_DONE), 0);
    @(posedge CK);
    #1;
    RST = 1'b0;
    PUSH_VALID = 1'b1;
    POP_READY = 1'b1;
    FLUSH = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge CK);
      #2;
      chk("scrub_wre", int'(RAM_WRE), 1);
      chk("scrub_wad", int'(RAM_WAD), i);
      chk("scrub_di", int'(RAM_DI), 0);
      chk("scrub_init_done", int'(INIT_DONE), 0);
      chk("scrub_push_ready", int'(PUSH_READY), 0);
      chk("scrub_pop_valid", int'(POP_VALID), 0);
      if (i == abort_at) begin
        @(posedge CK);
        #1;
        return;
      end
    end
    @(negedge CK);
    #2;
    chk("init_done_rise", int'(INIT_DONE), 1);
    for (int i = 0; i < 16; i++) chk("scrub_mem", int'(mem[i]), 0);
    PUSH_VALID = 1'b0;
    POP_READY = 1'b0;
    FLUSH = 1'b0;
    @(posedge CK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    PUSH_VALID = 1'b0;
    PUSH_DATA = 2'd0;
    POP_READY = 1'b0;
    FLUSH = 1'b0;
    @(posedge CK);
    #1;
    reset_seq(-1);
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) cyc(1'b1, 2'(i % 4), 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 1'b1, 1'b0);
    cyc(1'b1, 2'd3, 1'b0, 1'b0);
    goto_count(0);

    cyc(1'b1, 2'd2, 1'b1, 1'b0);
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0);

    goto_count(5);
    for (int i = 0; i < 20; i++) cyc(1'b1, 2'($urandom), 1'b1, 1'b0);
    chk("stream_count", int'(COUNT), 5);

    for (int i = 0; i < 200; i++) begin
      cyc($urandom_range(0, 9) < 7, 2'($urandom),
          $urandom_range(0, 9) < 6, 1'b0);
    end

    goto_count(9);
    cyc(1'b1, 2'd1, 1'b1, 1'b1);
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      cyc($urandom_range(0, 1) == 1, 2'($urandom),
          $urandom_range(0, 1) == 1, 1'b0);
    end

    goto_count(6);
    mon_en = 1'b0;
    reset_seq(7);
    reset_seq(-1);
    mon_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc($urandom_range(0, 9) < 6, 2'($urandom),
          $urandom_range(0, 9) < 6, 1'b0);
    end
    goto_count(0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
